// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee brew arbiter.
//
// Holds the FSM state encoding, default pricing parameters and the
// round-robin selection helper used by the top level.
package coffee_pkg;

    // State encoding of the service FSM
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GRANT   = 3'd1;
    localparam logic [2:0] ST_BREW    = 3'd2;
    localparam logic [2:0] ST_DELIVER = 3'd3;
    localparam logic [2:0] ST_REFUND  = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        GRANT   = ST_GRANT,
        BREW    = ST_BREW,
        DELIVER = ST_DELIVER,
        REFUND  = ST_REFUND
    } state_e;

    localparam int DEFAULT_PRICE      = 2;
    localparam int DEFAULT_MAX_CREDIT = 7;

    // Widest panel count the round-robin helper supports
    localparam int RR_MAX = 8;

    // Returns the first set bit of pending at or after ptr, wrapping at n.
    // Only the lowest n bits of pending are considered.
    function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] pending,
                                           input logic [2:0]        ptr,
                                           input int                n);
        logic [3:0] idx;
        logic [2:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < RR_MAX; i++) begin
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= 4'(n)) begin
                idx = idx - 4'(n);
            end
            if (i < n && !found && pending[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/coffee_panel_credit.sv
// Per-panel credit bookkeeping.
//
// Detects coin and buy rising edges, keeps a saturating credit counter,
// rejects coins that would overflow the counter and tracks whether a
// purchase is pending for this panel.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   coin, buy     raw panel levels; one event per 0->1 transition
//   dec           remove one credit (refund of leftover credit)
//   sub_price     charge one cup and clear the pending request (grant)
//   add_price     give one cup's worth back (brewer timeout)
//   credit        current credit
//   credit_next   credit after this cycle's updates
//   pending       a purchase is waiting for the brewer
//   reject        one-cycle refund pulse for a rejected coin
module coffee_panel_credit
    import coffee_pkg::*;
#(
    parameter int PRICE      = DEFAULT_PRICE,
    parameter int MAX_CREDIT = DEFAULT_MAX_CREDIT,
    parameter int CREDIT_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin,
    input  logic                buy,
    input  logic                dec,
    input  logic                sub_price,
    input  logic                add_price,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] credit_next,
    output logic                pending,
    output logic                reject
);

    // Two spare bits so the intermediate sum never wraps; the top bit
    // doubles as an underflow indicator.
    localparam int SUM_W = CREDIT_W + 2;

    logic                coin_q, buy_q;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                pending_q, pending_d;
    logic                reject_q, reject_d;
    logic                coin_rise, buy_rise;
    logic [SUM_W-1:0]    sum;

    // Credit arithmetic: a coin is rejected only when the counter is full
    // and nothing is being taken out this cycle, so a coin arriving during
    // a decrement simply cancels it out.
    always_comb begin
        coin_rise = coin & ~coin_q;
        buy_rise  = buy & ~buy_q;
        reject_d  = coin_rise && (credit_q == CREDIT_W'(MAX_CREDIT))
                    && !dec && !sub_price;

        sum = {2'b00, credit_q};
        if (coin_rise && !reject_d) sum = sum + SUM_W'(1);
        if (add_price)              sum = sum + SUM_W'(PRICE);
        if (sub_price)              sum = sum - SUM_W'(PRICE);
        if (dec)                    sum = sum - SUM_W'(1);

        if (sum[SUM_W-1]) begin
            credit_d = '0;
        end else if (sum > SUM_W'(MAX_CREDIT)) begin
            credit_d = CREDIT_W'(MAX_CREDIT);
        end else begin
            credit_d = sum[CREDIT_W-1:0];
        end

        // A panel that is having credit refunded cannot order, and an order
        // must still be affordable after this cycle's charge.
        pending_d = pending_q;
        if (sub_price) begin
            pending_d = 1'b0;
        end else if (buy_rise && !pending_q && !dec
                     && credit_q >= CREDIT_W'(PRICE)
                     && credit_d >= CREDIT_W'(PRICE)) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coin_q    <= 1'b0;
            buy_q     <= 1'b0;
            credit_q  <= '0;
            pending_q <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            coin_q    <= coin;
            buy_q     <= buy;
            credit_q  <= credit_d;
            pending_q <= pending_d;
            reject_q  <= reject_d;
        end
    end

    assign credit      = credit_q;
    assign credit_next = credit_d;
    assign pending     = pending_q;
    assign reject      = reject_q;

endmodule

// File: rtl/coffee_brew_arbiter.sv
// Shares one brewer between N_PANEL customer panels.
//
// Pending purchases are granted round-robin; the brewer is started with a
// one-cycle pulse and must answer with brew_done within BREW_TO cycles.
// After delivery any leftover credit of the served panel is refunded coin
// by coin. A brewer timeout sets a sticky fault that blocks new grants.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   coin, buy     per-panel coin and buy levels
//   brew_done     brewer completion pulse
//   brew_start    one-cycle brewer start pulse
//   coffee        one-cycle delivery pulse to the served panel
//   refund        one pulse per coin returned, per panel
//   grant_id      index of the panel being (or last) served
//   fault         sticky brewer-timeout flag
module coffee_brew_arbiter
    import coffee_pkg::*;
#(
    parameter int N_PANEL    = 2,
    parameter int PRICE      = DEFAULT_PRICE,
    parameter int MAX_CREDIT = DEFAULT_MAX_CREDIT,
    parameter int CREDIT_W   = 3,
    parameter int BREW_TO    = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_PANEL-1:0]         coin,
    input  logic [N_PANEL-1:0]         buy,
    input  logic                       brew_done,
    output logic                       brew_start,
    output logic [N_PANEL-1:0]         coffee,
    output logic [N_PANEL-1:0]         refund,
    output logic [$clog2(N_PANEL)-1:0] grant_id,
    output logic                       fault
);

    localparam int ID_W = $clog2(N_PANEL);
    localparam int TO_W = $clog2(BREW_TO + 1);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     g_q, g_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                fault_q, fault_d;

    logic [N_PANEL-1:0]  dec, sub_price, add_price, pending, reject;
    logic [CREDIT_W-1:0] credit      [N_PANEL];
    logic [CREDIT_W-1:0] credit_next [N_PANEL];
    logic [RR_MAX-1:0]   pend_ext;
    logic [2:0]          ptr_ext;
    logic [2:0]          pick;

    for (genvar i = 0; i < N_PANEL; i++) begin : g_panel
        coffee_panel_credit #(
            .PRICE      (PRICE),
            .MAX_CREDIT (MAX_CREDIT),
            .CREDIT_W   (CREDIT_W)
        ) u_panel (
            .clk         (clk),
            .rst_n       (rst_n),
            .coin        (coin[i]),
            .buy         (buy[i]),
            .dec         (dec[i]),
            .sub_price   (sub_price[i]),
            .add_price   (add_price[i]),
            .credit      (credit[i]),
            .credit_next (credit_next[i]),
            .pending     (pending[i]),
            .reject      (reject[i])
        );
    end

    // Round-robin candidate, widened to the helper's fixed width
    always_comb begin
        pend_ext                = '0;
        pend_ext[N_PANEL-1:0]   = pending;
        ptr_ext                 = '0;
        ptr_ext[ID_W-1:0]       = rr_ptr_q;
        pick                    = rr_pick(pend_ext, ptr_ext, N_PANEL);
    end

    // Next-state logic and the credit controls sent to the served panel
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        rr_ptr_d  = rr_ptr_q;
        to_cnt_d  = '0;
        fault_d   = fault_q;
        dec       = '0;
        sub_price = '0;
        add_price = '0;

        case (state_q)
            IDLE: begin
                if (!fault_q && pending != '0) begin
                    g_d     = pick[ID_W-1:0];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                sub_price[g_q] = 1'b1;
                rr_ptr_d = (g_q == ID_W'(N_PANEL - 1)) ? '0 : g_q + ID_W'(1);
                state_d  = BREW;
            end
            BREW: begin
                // Completion wins over a timeout landing in the same cycle
                if (brew_done) begin
                    state_d = DELIVER;
                end else if (to_cnt_q == TO_W'(BREW_TO - 1)) begin
                    fault_d        = 1'b1;
                    add_price[g_q] = 1'b1;
                    state_d        = REFUND;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            DELIVER: begin
                // A repeat order keeps its credit for the next cup
                if (credit[g_q] == '0 || pending[g_q]) begin
                    state_d = IDLE;
                end else begin
                    state_d = REFUND;
                end
            end
            REFUND: begin
                if (credit[g_q] != '0) begin
                    dec[g_q] = 1'b1;
                end
                // Coins landing now keep the refund going
                if (credit_next[g_q] == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            g_q      <= '0;
            rr_ptr_q <= '0;
            to_cnt_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            rr_ptr_q <= rr_ptr_d;
            to_cnt_q <= to_cnt_d;
            fault_q  <= fault_d;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        brew_start = (state_q == GRANT);
        coffee     = '0;
        refund     = reject;
        if (state_q == DELIVER) begin
            coffee[g_q] = 1'b1;
        end
        if (state_q == REFUND && credit[g_q] != '0) begin
            refund[g_q] = 1'b1;
        end
    end

    assign grant_id = g_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_coffee_brew_arbiter.sv
// Directed self-checking bench for coffee_brew_arbiter (N_PANEL=2, PRICE=2).
module tb_coffee_brew_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] coin;
    logic [1:0] buy;
    logic       brew_done;
    logic       brew_start;
    logic [1:0] coffee;
    logic [1:0] refund;
    logic [0:0] grant_id;
    logic       fault;

    int test_count = 0;
    int fail_count = 0;

    int tot_start  = 0;
    int tot_coffee [2];
    int tot_refund [2];

    int base_start;
    int base_coffee0;
    int base_refund0;
    int base_refund1;
    bit ok;
    int n;

    coffee_brew_arbiter #(
        .N_PANEL    (2),
        .PRICE      (2),
        .MAX_CREDIT (7),
        .CREDIT_W   (3),
        .BREW_TO    (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin       (coin),
        .buy        (buy),
        .brew_done  (brew_done),
        .brew_start (brew_start),
        .coffee     (coffee),
        .refund     (refund),
        .grant_id   (grant_id),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge
    initial begin
        tot_coffee[0] = 0;
        tot_coffee[1] = 0;
        tot_refund[0] = 0;
        tot_refund[1] = 0;
    end

    always @(negedge clk) begin
        if (brew_start) tot_start++;
        for (int i = 0; i < 2; i++) begin
            if (coffee[i]) tot_coffee[i]++;
            if (refund[i]) tot_refund[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int actual, input int expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One cycle of the given levels followed by one cycle low
    task automatic applyStimulus(input logic [1:0] coin_mask, input logic [1:0] buy_mask);
        coin = coin_mask;
        buy  = buy_mask;
        tick();
        coin = 2'b00;
        buy  = 2'b00;
        tick();
    endtask

    task automatic waitStart(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (brew_start) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Leaves the bench in the DELIVER cycle
    task automatic finishBrew(input int delay);
        repeat (delay) tick();
        brew_done = 1'b1;
        tick();
        brew_done = 1'b0;
    endtask

    task automatic settle();
        repeat (15) tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        coin      = 2'b00;
        buy       = 2'b00;
        brew_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rst_brew_start", brew_start, 0);
        checkOutput("rst_coffee", coffee, 0);
        checkOutput("rst_refund", refund, 0);
        checkOutput("rst_grant_id", grant_id, 0);
        checkOutput("rst_fault", fault, 0);
        rst_n = 1'b1;
        tick();

        // Basic purchase: 3 coins, buy, one leftover coin refunded
        base_start   = tot_start;
        base_refund0 = tot_refund[0];
        repeat (3) applyStimulus(2'b01, 2'b00);
        buy = 2'b01;
        tick();
        checkOutput("basic_start_k", brew_start, 0);
        buy = 2'b00;
        tick();
        checkOutput("basic_start_k1", brew_start, 1);
        checkOutput("basic_grant_id", grant_id, 0);
        tick();
        checkOutput("basic_start_k2", brew_start, 0);
        finishBrew(5);
        checkOutput("basic_coffee", coffee, 1);
        tick();
        checkOutput("basic_refund_on", refund, 1);
        tick();
        checkOutput("basic_refund_off", refund, 0);
        settle();
        checkOutput("basic_start_count", tot_start - base_start, 1);
        checkOutput("basic_refund_count", tot_refund[0] - base_refund0, 1);

        // Insufficient credit: one coin is not enough
        base_start   = tot_start;
        base_refund1 = tot_refund[1];
        applyStimulus(2'b10, 2'b00);
        applyStimulus(2'b00, 2'b10);
        repeat (8) tick();
        checkOutput("poor_no_start", tot_start - base_start, 0);
        applyStimulus(2'b10, 2'b00);
        applyStimulus(2'b00, 2'b10);
        waitStart(ok);
        checkOutput("poor_start_seen", ok, 1);
        checkOutput("poor_grant_id", grant_id, 1);
        finishBrew(3);
        checkOutput("poor_coffee", coffee, 2);
        settle();
        checkOutput("poor_no_refund", tot_refund[1] - base_refund1, 0);

        // Round robin with pointer at 0: panel0 first
        repeat (2) applyStimulus(2'b11, 2'b00);
        applyStimulus(2'b00, 2'b11);
        waitStart(ok);
        checkOutput("rr0_first_grant", grant_id, 0);
        finishBrew(2);
        checkOutput("rr0_first_coffee", coffee, 1);
        waitStart(ok);
        checkOutput("rr0_second_seen", ok, 1);
        checkOutput("rr0_second_grant", grant_id, 1);
        finishBrew(2);
        checkOutput("rr0_second_coffee", coffee, 2);
        settle();

        // Serve panel0 alone so the pointer moves to panel1
        repeat (2) applyStimulus(2'b01, 2'b00);
        applyStimulus(2'b00, 2'b01);
        waitStart(ok);
        checkOutput("rr_solo_grant", grant_id, 0);
        finishBrew(2);
        settle();

        // Repeat the simultaneous buy: panel1's turn comes first
        repeat (2) applyStimulus(2'b11, 2'b00);
        applyStimulus(2'b00, 2'b11);
        waitStart(ok);
        checkOutput("rr1_first_grant", grant_id, 1);
        finishBrew(2);
        checkOutput("rr1_first_coffee", coffee, 2);
        waitStart(ok);
        checkOutput("rr1_second_grant", grant_id, 0);
        finishBrew(2);
        checkOutput("rr1_second_coffee", coffee, 1);
        settle();

        // Saturation: 8 coins give credit 7 and one rejected coin
        base_refund0 = tot_refund[0];
        repeat (8) applyStimulus(2'b01, 2'b00);
        tick();
        checkOutput("sat_reject_count", tot_refund[0] - base_refund0, 1);
        base_refund0 = tot_refund[0];
        applyStimulus(2'b00, 2'b01);
        waitStart(ok);
        checkOutput("sat_grant", grant_id, 0);
        finishBrew(3);
        checkOutput("sat_coffee", coffee, 1);
        settle();
        checkOutput("sat_refund_count", tot_refund[0] - base_refund0, 5);

        // Timeout: brewer never answers
        base_refund0 = tot_refund[0];
        base_coffee0 = tot_coffee[0];
        repeat (2) applyStimulus(2'b01, 2'b00);
        applyStimulus(2'b00, 2'b01);
        waitStart(ok);
        checkOutput("to_start_seen", ok, 1);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (fault) begin
                n = i;
                break;
            end
        end
        checkOutput("to_fault_latency", n, 65);
        settle();
        checkOutput("to_no_coffee", tot_coffee[0] - base_coffee0, 0);
        checkOutput("to_refund_count", tot_refund[0] - base_refund0, 2);
        base_start = tot_start;
        repeat (2) applyStimulus(2'b10, 2'b00);
        applyStimulus(2'b00, 2'b10);
        repeat (20) tick();
        checkOutput("to_no_new_grant", tot_start - base_start, 0);
        checkOutput("to_fault_sticky", fault, 1);

        // Reset in the middle of a brew
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        checkOutput("rst2_fault_clear", fault, 0);
        repeat (2) applyStimulus(2'b11, 2'b00);
        applyStimulus(2'b00, 2'b10);
        waitStart(ok);
        checkOutput("rst2_grant", grant_id, 1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_brew_start", brew_start, 0);
        checkOutput("rst2_coffee", coffee, 0);
        checkOutput("rst2_refund", refund, 0);
        checkOutput("rst2_grant_id", grant_id, 0);
        checkOutput("rst2_fault", fault, 0);
        #3;
        rst_n = 1'b1;
        tick();
        base_start   = tot_start;
        base_refund0 = tot_refund[0];
        base_refund1 = tot_refund[1];
        brew_done = 1'b1;
        tick();
        checkOutput("rst2_late_done", coffee, 0);
        brew_done = 1'b0;
        applyStimulus(2'b00, 2'b01);
        repeat (10) tick();
        checkOutput("rst2_credit_lost", tot_start - base_start, 0);
        checkOutput("rst2_no_refund0", tot_refund[0] - base_refund0, 0);
        checkOutput("rst2_no_refund1", tot_refund[1] - base_refund1, 0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/coffee_brew_arbiter.md
Name: coffee_brew_arbiter

Overview:
- Shares one brewing unit between N_PANEL customer panels.
- Each panel has its own coin and buy inputs and a per-panel credit counter.
- A round-robin arbiter grants pending purchases, sequences the brewer with a start/done handshake, delivers the cup and refunds leftover credit.
- Sits between the panel inputs and the single brewer datapath.

Parameters:
N_PANEL, 2, number of customer panels (2..8)
PRICE, 2, coins per cup (>=1)
MAX_CREDIT, 7, credit saturation value per panel (>=PRICE)
CREDIT_W, 3, credit counter width; must hold MAX_CREDIT
BREW_TO, 64, max cycles in BREW before fault

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
coin  input  N_PANEL  per-panel coin level; one coin per 0->1 transition
buy  input  N_PANEL  per-panel buy level; request on 0->1 transition
brew_done  input  1  brewer completion, single-cycle pulse
brew_start  output  1  one-cycle pulse starting the brewer
coffee  output  N_PANEL  one-cycle delivery pulse to the granted panel
refund  output  N_PANEL  one pulse per coin returned
grant_id  output  $clog2(N_PANEL)  index of the panel being served
fault  output  1  sticky brewer-timeout flag, cleared only by reset

Behaviour:
- Clocking and reset: single clock domain, rst_n asynchronous active-low.
- Reset values: state IDLE, all credits 0, pending 0, edge registers 0, RR pointer 0, timeout counter 0, all outputs 0.
- Reset mid-operation aborts the service; credit is lost and no refund is issued.
- Edge detect: coin_q and buy_q are registered; rise = in & ~q.
- Coin rise, normal case: credit[i]++ at that edge.
  - If credit[i]==MAX_CREDIT and no decrement happens that cycle, the coin is rejected instead: refund[i]=1 in the following cycle. Credit is unchanged.
- Buy rise: sets pending[i] only if credit[i]>=PRICE and pending[i]==0. Otherwise ignored, with no response.
- Same-cycle increment and decrement on one panel give a net change of 0, with no rejection.
- FSM (Moore outputs decoded from the state register). States: IDLE, GRANT, BREW, DELIVER, REFUND.
  - IDLE: if pending!=0, pick the first set bit at or after rr_ptr (wrapping), latch g, go to GRANT.
  - GRANT (1 cycle): brew_start=1; credit[g]-=PRICE; pending[g]=0; rr_ptr=g+1 mod N_PANEL; go to BREW.
  - BREW: the timeout counter counts up. brew_done -> DELIVER.
    - If the counter reaches BREW_TO first: set fault, credit[g]+=PRICE (saturating), go to REFUND. No coffee pulse.
    - brew_done outside BREW is ignored.
  - DELIVER (1 cycle): coffee[g]=1. Go to IDLE if credit[g]==0 or pending[g]==1 (a second cup was ordered during service). Otherwise go to REFUND.
  - REFUND: refund[g]=1 and credit[g]-- each cycle while credit[g]>0. Go to IDLE in the cycle credit[g] reaches 0.
    - Coins arriving on g during REFUND are credited and therefore also refunded.
- While fault=1: no new grants, IDLE holds, coins still credited.
- grant_id holds g from GRANT through REFUND and holds its last value in IDLE.
- Latency, buy rise sampled at edge k with credit sufficient:
  - pending set at k
  - GRANT state at k+1
  - brew_start visible in cycle k+1..k+2
- Other panels keep accepting coins and buys during any service.

Decomposition:
- Package coffee_pkg:
  - state encoding localparams (IDLE=0..REFUND=4)
  - default PRICE and MAX_CREDIT
  - a function rr_pick(pending, ptr) returning the next index
- Sub-module coffee_panel_credit, instantiated N_PANEL times:
  - coin/buy edge detect
  - saturating credit counter with inc/dec/add-PRICE controls
  - reject-refund generation
  - pending flag
- The top level holds the FSM, the RR pointer, the timeout counter and output muxing.

Test Plan:
- Basic purchase (N=2, PRICE=2): panel0 gives 3 coin rises, then buy rise. Required response:
  - brew_start 1 cycle
  - brew_done after 5 cycles -> coffee[0] 1 cycle
  - refund[0] exactly 1 pulse, credit0 returns to 0, FSM back in IDLE
- Insufficient credit: panel1 gives 1 coin, then buy -> no pending, no brew_start. A second coin then buy -> served normally.
- Round-robin: both panels at credit 2 raise buy in the same cycle with rr_ptr=0. Required response:
  - panel0 served first, then panel1
  - a repeat of the simultaneous buy serves panel1's turn before panel0's
- Saturation: 8 coin rises on panel0 -> credit 7, exactly 1 refund[0] pulse; later service refunds 5 after delivery.
- Timeout: grant panel0 (credit 2), withhold brew_done -> after 64 BREW cycles fault=1, no coffee, refund[0] 2 pulses, subsequent buys not granted.
- Reset mid-BREW: assert rst_n=0 during BREW -> all outputs 0 immediately and credits 0; after release, a late brew_done is ignored.
